ctrl_pipe: RTL

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe_pkg.sv | 21 ++
 rtl/ctrl_pipe_stage.sv | 51 +++++
 rtl/ctrl_pipe.sv | 115 +++++++++++
 3 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and types for the control pipeline: control-word bit
// positions, performance counter width, and the per-stage action encoding.
package ctrl_pipe_pkg;

  // Control-word bit positions
  localparam int WE_BIT_DEFAULT = 0;  // register-write enable
  localparam int MEM_RD_BIT     = 1;  // memory read
  localparam int MEM_WR_BIT     = 2;  // memory write
  localparam int HILO_WE_BIT    = 3;  // hi/lo register write

  // Performance counter width
  localparam int CNT_W = 32;

  // What a stage register does on the next edge
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,  // take the word offered by the upstream source
    ACT_HOLD   = 2'd1,  // keep the current word
    ACT_BUBBLE = 2'd2   // become an empty slot
  } stage_act_e;

endpackage : ctrl_pipe_pkg

// File: rtl/ctrl_pipe_stage.sv
// One control-pipeline stage register: load / hold / bubble, with an
// optional clear of the write-enable bit on whatever word is being kept.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int CW     = 16,
  parameter int WE_BIT = WE_BIT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  stage_act_e    act,
  input  logic          kill_we,
  input  logic [CW-1:0] in_ctrl,
  input  logic          in_valid,
  output logic [CW-1:0] ctrl_q,
  output logic          valid_q
);

  logic [CW-1:0] ctrl_d;
  logic          valid_d;

  // Select the next word; kill_we strips register-write from it
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    case (act)
      ACT_LOAD: begin
        ctrl_d  = in_ctrl;
        valid_d = in_valid;
      end
      ACT_BUBBLE: begin
        ctrl_d  = '0;
        valid_d = 1'b0;
      end
      default: ;
    endcase
    if (kill_we) ctrl_d[WE_BIT] = 1'b0;
  end

  // Stage register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

endmodule : ctrl_pipe_stage

// File: rtl/ctrl_pipe.sv
// Control-word pipeline after decode: NSTAGE stage registers with
// back-propagating stall, per-stage flush, and exception handling that
// strips register-write from the faulting instruction.
// Optional macro CTRL_PIPE_PERF_EN adds bubble_cnt / flush_cnt counters.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int NSTAGE    = 3,
  parameter int CW        = 16,
  parameter int WE_BIT    = WE_BIT_DEFAULT,
  parameter int EXC_STAGE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CW-1:0]        ctrl_d,
  input  logic                 valid_d,
  input  logic [NSTAGE-1:0]    stall,
  input  logic [NSTAGE-1:0]    flush,
  input  logic                 exc,
  output logic [NSTAGE*CW-1:0] ctrl_o,
  output logic [NSTAGE-1:0]    valid_o,
  output logic [NSTAGE-1:0]    we_o
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt
`endif
);

  logic [NSTAGE-1:0] seff;      // effective stall per stage
  logic              exc_acc;   // exception applies to a real instruction
  logic              exc_pass;  // excepting word moves on this edge

  assign exc_acc  = exc & valid_o[EXC_STAGE];
  assign exc_pass = exc_acc & ~seff[EXC_STAGE];

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
      logic [CW-1:0] in_ctrl;
      logic          in_valid;
      stage_act_e    act;
      logic          kill_we;

      // A stall anywhere downstream freezes this stage
      assign seff[gi] = |stall[NSTAGE-1:gi];

      if (gi == 0) begin : g_src_dec
        assign in_ctrl  = ctrl_d;
        assign in_valid = valid_d;
      end else begin : g_src_prev
        // A stalled upstream stage hands down a bubble instead of its word
        assign in_ctrl  = seff[gi-1] ? '0 : ctrl_o[(gi-1)*CW +: CW];
        assign in_valid = ~seff[gi-1] & valid_o[gi-1];
      end

      // Flush and exception squash beat hold, hold beats load
      always_comb begin
        if (flush[gi] || (exc_pass && (gi <= EXC_STAGE))) act = ACT_BUBBLE;
        else if (seff[gi])                                 act = ACT_HOLD;
        else                                               act = ACT_LOAD;
      end

      // Strip write-enable either in place (stalled) or on the way out
      assign kill_we = ((gi == EXC_STAGE)     && exc_acc && seff[gi]) ||
                       ((gi == EXC_STAGE + 1) && exc_pass);

      ctrl_pipe_stage #(
        .CW     (CW),
        .WE_BIT (WE_BIT)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .act      (act),
        .kill_we  (kill_we),
        .in_ctrl  (in_ctrl),
        .in_valid (in_valid),
        .ctrl_q   (ctrl_o[gi*CW +: CW]),
        .valid_q  (valid_o[gi])
      );

      assign we_o[gi] = valid_o[gi] & ctrl_o[gi*CW + WE_BIT];
    end
  endgenerate

`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

  // Saturating counts of empty last-stage cycles and flush/exception cycles
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!valid_o[NSTAGE-1] && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    if (((|flush) || exc_acc) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule : ctrl_pipe
